// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan display: glyph constants, digit slots,
// the per-frame input snapshot and the active-low hex font.
package seg7_pkg;

    localparam logic [6:0] GLYPH_U     = 7'h41;
    localparam logic [6:0] GLYPH_D     = 7'h21;
    localparam logic [6:0] GLYPH_DASH  = 7'h3F;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        DIGIT_COUNT = 2'd0,
        DIGIT_MAX   = 2'd1,
        DIGIT_DIR   = 2'd2,
        DIGIT_WRAP  = 2'd3
    } digit_e;

    typedef struct packed {
        logic [3:0] count;
        logic [3:0] max_count;
        logic       direction;
    } snapshot_t;

    // Segment order {g,f,e,d,c,b,a}, a 0 lights the segment.
    function automatic logic [6:0] hex_glyph(input logic [3:0] value);
        logic [6:0] glyph;
        case (value)
            4'h0:    glyph = 7'h40;
            4'h1:    glyph = 7'h79;
            4'h2:    glyph = 7'h24;
            4'h3:    glyph = 7'h30;
            4'h4:    glyph = 7'h19;
            4'h5:    glyph = 7'h12;
            4'h6:    glyph = 7'h02;
            4'h7:    glyph = 7'h78;
            4'h8:    glyph = 7'h00;
            4'h9:    glyph = 7'h10;
            4'hA:    glyph = 7'h08;
            4'hB:    glyph = 7'h03;
            4'hC:    glyph = 7'h46;
            4'hD:    glyph = 7'h21;
            4'hE:    glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational 4-bit to active-low 7-segment hex font decoder.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] glyph
);

    assign glyph = hex_glyph(value);

endmodule

// File: rtl/count_seg_scan.sv
// Four-digit multiplexed 7-segment display for the modulo-N counter: count, limit,
// direction and wrap flag, all taken from one snapshot latched per scan frame.
module count_seg_scan
    import seg7_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] count,
    input  logic [3:0] max_count,
    input  logic       direction,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_pulse
);

    localparam int              PW        = $clog2(DIV);
    localparam logic [PW-1:0]   SLOT_LAST = PW'(DIV - 1);

    logic [PW-1:0] prescaler;
    digit_e        index;
    snapshot_t     snap;

    logic       slot_end;
    logic       frame_end;
    logic       wrap_flag;
    logic [3:0] hex_value;
    logic [6:0] hex_seg;
    logic [3:0] an_next;
    logic [6:0] seg_next;
    logic       dp_next;

    assign slot_end  = (prescaler == SLOT_LAST);
    assign frame_end = slot_end && (index == DIGIT_WRAP);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler   <= '0;
            index       <= DIGIT_COUNT;
            snap        <= '0;
            frame_pulse <= 1'b0;
        end else begin
            prescaler   <= slot_end ? '0 : prescaler + PW'(1);
            frame_pulse <= frame_end;
            if (slot_end)
                index <= digit_e'(index + 2'd1);
            if (frame_end)
                snap <= '{count: count, max_count: max_count, direction: direction};
        end
    end

    // One shared decoder; only d0 and d1 ever show a hex value.
    assign hex_value = (index == DIGIT_MAX) ? snap.max_count : snap.count;

    seg7_hex_decoder u_hex (
        .value (hex_value),
        .glyph (hex_seg)
    );

    assign wrap_flag = snap.direction ? (snap.count == snap.max_count)
                                      : (snap.count == 4'd0);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        an_next  = 4'b1111;
        seg_next = GLYPH_BLANK;
        dp_next  = 1'b1;
        if (int'(prescaler) >= BLANK) begin
            an_next = ~(4'b0001 << index);
            case (index)
                DIGIT_COUNT: seg_next = hex_seg;
                DIGIT_MAX: begin
                    seg_next = hex_seg;
                    dp_next  = 1'b0;
                end
                DIGIT_DIR:   seg_next = snap.direction ? GLYPH_U : GLYPH_D;
                default:     seg_next = wrap_flag ? GLYPH_DASH : GLYPH_BLANK;
            endcase
        end
    end

    // Registered drive keeps all anode bits switching from one flop edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= GLYPH_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_count_seg_scan.sv
// Directed bench for count_seg_scan: DIV=8/BLANK=2 main instance plus a DIV=4/BLANK=0 instance.
module tb_count_seg_scan;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] count;
    logic [3:0] max_count;
    logic       direction;

    logic [3:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;
    logic       fp_a, fp_b;

    int checks = 0;
    int passes = 0;

    logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    count_seg_scan #(.DIV(8), .BLANK(2)) dut_a (
        .clk         (clk),
        .reset       (reset),
        .count       (count),
        .max_count   (max_count),
        .direction   (direction),
        .an          (an_a),
        .seg         (seg_a),
        .dp          (dp_a),
        .frame_pulse (fp_a)
    );

    count_seg_scan #(.DIV(4), .BLANK(0)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .count       (count),
        .max_count   (max_count),
        .direction   (direction),
        .an          (an_b),
        .seg         (seg_b),
        .dp          (dp_b),
        .frame_pulse (fp_b)
    );

    always #5 clk = ~clk;

    // Returns on the negedge where frame_pulse of the selected instance is seen high.
    task automatic wait_pulse(input bit use_b);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if ((use_b ? fp_b : fp_a) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            $display("FAIL wait_pulse(b=%0d): frame_pulse stayed 0, required 1 within 100 cycles", use_b);
        end
    endtask

    task automatic test_reset();
        wait_pulse(1'b0);
        repeat (20) @(negedge clk);
        checks++;
        if (an_a !== 4'b1011) $display("FAIL reset_pre_an: got %b want 1011", an_a);
        else passes++;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (an_a !== 4'b1111) $display("FAIL reset_async_an: got %b want 1111", an_a);
        else passes++;
        checks++;
        if (seg_a !== 7'h7F) $display("FAIL reset_async_seg: got %h want 7f", seg_a);
        else passes++;
        checks++;
        if (dp_a !== 1'b1 || fp_a !== 1'b0)
            $display("FAIL reset_async_dp_fp: got dp=%b fp=%b want dp=1 fp=0", dp_a, fp_a);
        else passes++;
        @(negedge clk);
        checks++;
        if (an_a !== 4'b1111 || seg_a !== 7'h7F)
            $display("FAIL reset_held: got an=%b seg=%h want an=1111 seg=7f", an_a, seg_a);
        else passes++;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (an_a !== 4'b1111) $display("FAIL reset_blank_after: got %b want 1111", an_a);
        else passes++;
        @(negedge clk);
        checks++;
        if (an_a !== 4'b1110 || seg_a !== 7'h40 || dp_a !== 1'b1)
            $display("FAIL reset_first_d0: got an=%b seg=%h dp=%b want an=1110 seg=40 dp=1",
                     an_a, seg_a, dp_a);
        else passes++;
    endtask

    task automatic test_scan_order();
        logic [6:0] exp_d [4];
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        int         p, i;
        exp_d = '{7'h12, 7'h10, 7'h41, 7'h7F};
        count = 4'h5; max_count = 4'h9; direction = 1'b1;
        wait_pulse(1'b0);
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            p = (j - 1) % 8;
            i = (j - 1) / 8;
            exp_an  = (p < 2) ? 4'b1111 : ~(4'b0001 << i);
            exp_seg = (p < 2) ? 7'h7F : exp_d[i];
            exp_dp  = (p >= 2 && i == 1) ? 1'b0 : 1'b1;
            checks++;
            if (an_a !== exp_an) $display("FAIL scan_an[%0d]: got %b want %b", j, an_a, exp_an);
            else passes++;
            checks++;
            if (seg_a !== exp_seg) $display("FAIL scan_seg[%0d]: got %h want %h", j, seg_a, exp_seg);
            else passes++;
            checks++;
            if (dp_a !== exp_dp) $display("FAIL scan_dp[%0d]: got %b want %b", j, dp_a, exp_dp);
            else passes++;
            checks++;
            if (fp_a !== (j == 32)) $display("FAIL scan_fp[%0d]: got %b want %b", j, fp_a, j == 32);
            else passes++;
        end
    endtask

    task automatic test_wrap_flag();
        logic [3:0] c   [3];
        logic       d   [3];
        logic [6:0] e2  [3];
        logic [6:0] e3  [3];
        c  = '{4'h9, 4'h0, 4'h3};
        d  = '{1'b1, 1'b0, 1'b0};
        e2 = '{7'h41, 7'h21, 7'h21};
        e3 = '{7'h3F, 7'h3F, 7'h7F};
        for (int k = 0; k < 3; k++) begin
            count = c[k]; max_count = 4'h9; direction = d[k];
            wait_pulse(1'b0);
            repeat (20) @(negedge clk);
            checks++;
            if (an_a !== 4'b1011 || seg_a !== e2[k])
                $display("FAIL wrap_d2[%0d]: got an=%b seg=%h want an=1011 seg=%h", k, an_a, seg_a, e2[k]);
            else passes++;
            repeat (8) @(negedge clk);
            checks++;
            if (an_a !== 4'b0111 || seg_a !== e3[k] || dp_a !== 1'b1)
                $display("FAIL wrap_d3[%0d]: got an=%b seg=%h dp=%b want an=0111 seg=%h dp=1",
                         k, an_a, seg_a, dp_a, e3[k]);
            else passes++;
        end
    endtask

    task automatic test_snapshot_coherence();
        int pulses;
        pulses = 0;
        count = 4'h5; max_count = 4'h9; direction = 1'b1;
        wait_pulse(1'b0);
        for (int j = 1; j <= 64; j++) begin
            @(negedge clk);
            if (fp_a === 1'b1) pulses++;
            if (j == 5) begin
                checks++;
                if (an_a !== 4'b1110 || seg_a !== 7'h12)
                    $display("FAIL coherent_old_d0: got an=%b seg=%h want an=1110 seg=12", an_a, seg_a);
                else passes++;
            end
            if (j == 32 || j == 64) begin
                checks++;
                if (fp_a !== 1'b1) $display("FAIL coherent_fp[%0d]: got %b want 1", j, fp_a);
                else passes++;
            end
            if (j == 37) begin
                checks++;
                if (an_a !== 4'b1110 || seg_a !== 7'h78)
                    $display("FAIL coherent_new_d0: got an=%b seg=%h want an=1110 seg=78", an_a, seg_a);
                else passes++;
            end
            if (j == 1)  count = 4'h6;
            if (j == 12) count = 4'h7;
        end
        checks++;
        if (pulses != 2) $display("FAIL coherent_pulse_count: got %0d want 2", pulses);
        else passes++;
    endtask

    task automatic test_hex_font();
        max_count = 4'hF; direction = 1'b1;
        for (int v = 0; v < 16; v++) begin
            count = 4'(v);
            wait_pulse(1'b0);
            repeat (5) @(negedge clk);
            checks++;
            if (an_a !== 4'b1110 || seg_a !== font[v])
                $display("FAIL font[%0d]: got an=%b seg=%h want an=1110 seg=%h", v, an_a, seg_a, font[v]);
            else passes++;
        end
    endtask

    task automatic test_no_blank();
        logic [6:0] exp_d [4];
        logic [3:0] exp_an;
        int         i;
        exp_d = '{7'h0E, 7'h0E, 7'h41, 7'h3F};
        wait_pulse(1'b1);
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            i = ((j - 1) / 4) % 4;
            exp_an = ~(4'b0001 << i);
            checks++;
            if (an_b !== exp_an) $display("FAIL noblank_an[%0d]: got %b want %b", j, an_b, exp_an);
            else passes++;
            checks++;
            if (seg_b !== exp_d[i] || dp_b !== (i != 1))
                $display("FAIL noblank_seg[%0d]: got seg=%h dp=%b want seg=%h dp=%b",
                         j, seg_b, dp_b, exp_d[i], i != 1);
            else passes++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; count = 4'h0; max_count = 4'h0; direction = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_scan_order();
        test_wrap_flag();
        test_snapshot_coherence();
        test_hex_font();
        test_no_blank();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
